// File: rtl/redirect_pkg.sv
// Shared types and constants for the redirect/hazard controller.
// Holds the controller state enum, register-address width and the debug view struct.
package redirect_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Internal controller state, exported for checkers and debug probes.
    typedef struct packed {
        state_t                 state;
        logic [DRAIN_CNT_W-1:0] drain_cnt;
        logic                   halt_pending;
        logic                   resume_redirect;
    } dbg_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// register is read by the instruction currently in ID.
module hazard_detect
    import redirect_pkg::*;
(
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    output logic                  load_use
);

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    assign load_use = idex_mem_read && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect, load-use stall and halt/drain/resume controller.
// Optional performance counters are enabled by defining REDIRECT_CTRL_PERF_EN.
module redirect_ctrl
    import redirect_pkg::*;
#(
    parameter int PC_W         = 9,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_pc_sel,
    input  logic [31:0]           ex_br_pc,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  halted,
    output logic                  misalign_err,
    output logic [31:0]           taken_count,
    output logic [31:0]           stall_count,
    output dbg_t                  dbg
);

    state_t                 state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   halt_pending;
    logic                   resume_redirect;
    logic [PC_W-1:0]        resume_pc;
    logic                   misalign_q;

    logic load_use;
    logic take_ex;
    logic take_resume;
    logic do_stall;
    logic misalign_hit;
    logic unused_br_bits;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .load_use      (load_use)
    );

    assign unused_br_bits = ^ex_br_pc;

    // Priority in RUN: EX redirect, then deferred resume redirect, then halt, then load-use.
    assign take_ex      = (state == RUN) && ex_pc_sel;
    assign take_resume  = (state == RUN) && !ex_pc_sel && resume_redirect;
    assign do_stall     = (state == RUN) && !ex_pc_sel && !resume_redirect &&
                          !halt_req && load_use;
    assign misalign_hit = ex_pc_sel && (ex_br_pc[1:0] != 2'b00) &&
                          ((state == RUN) || (state == DRAIN));

    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;
        case (state)
            RUN: begin
                if (take_ex) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ex_br_pc[PC_W-1:0];
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                end else if (take_resume) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = resume_pc;
                end else if (do_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
            end
            HALTED: begin
                halted     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            drain_cnt       <= '0;
            halt_pending    <= 1'b0;
            resume_redirect <= 1'b0;
            resume_pc       <= '0;
            misalign_q      <= 1'b0;
        end else begin
            if (misalign_hit) begin
                misalign_q <= 1'b1;
            end
            case (state)
                RUN: begin
                    // Any deferred target is consumed in the first RUN cycle.
                    resume_redirect <= 1'b0;
                    halt_pending    <= ex_pc_sel && halt_req;
                    if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (ex_pc_sel) begin
                        resume_pc       <= ex_br_pc[PC_W-1:0];
                        resume_redirect <= 1'b1;
                    end
                    if (drain_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef REDIRECT_CTRL_PERF_EN
    logic [31:0] taken_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= '0;
            stall_q <= '0;
        end else begin
            if (take_ex && (taken_q != 32'hFFFF_FFFF)) begin
                taken_q <= taken_q + 32'd1;
            end
            if (do_stall && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign taken_count = taken_q;
    assign stall_count = stall_q;
`else
    assign taken_count = '0;
    assign stall_count = '0;
`endif

    assign misalign_err = misalign_q;

    assign dbg.state           = state;
    assign dbg.drain_cnt       = drain_cnt;
    assign dbg.halt_pending    = halt_pending;
    assign dbg.resume_redirect = resume_redirect;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the controller.
module tb_redirect_ctrl;
    import redirect_pkg::*;

    localparam int PC_W = 9;
    localparam int DRAIN_CYCLES = 3;

    localparam int M_RUN = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALTED = 2;

    logic            clk;
    logic            reset;
    logic            ex_pc_sel;
    logic [31:0]     ex_br_pc;
    logic            idex_mem_read;
    logic [4:0]      idex_rd;
    logic [4:0]      ifid_rs1;
    logic [4:0]      ifid_rs2;
    logic            halt_req;
    logic            resume;
    logic            pc_write;
    logic            ifid_write;
    logic            ifid_flush;
    logic            idex_flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;
    logic            misalign_err;
    logic [31:0]     taken_count;
    logic [31:0]     stall_count;
    dbg_t            dbg;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int              m_mode;
    int              m_left;
    bit              m_have_target;
    logic [PC_W-1:0] m_target;
    bit              m_sticky;
    longint unsigned m_taken;
    longint unsigned m_stall;

    // Expected outputs for the current cycle
    logic            e_pc_write, e_ifid_write, e_ifid_flush, e_idex_flush;
    logic            e_rv, e_halted;
    logic [PC_W-1:0] e_pc;

    redirect_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_pc_sel      (ex_pc_sel),
        .ex_br_pc       (ex_br_pc),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .taken_count    (taken_count),
        .stall_count    (stall_count),
        .dbg            (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_load_use();
        return idex_mem_read && (idex_rd != 5'd0) &&
               ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    endfunction

    task automatic model_reset();
        m_mode = M_RUN;
        m_left = 0;
        m_have_target = 0;
        m_target = '0;
        m_sticky = 0;
        m_taken = 0;
        m_stall = 0;
    endtask

    task automatic model_outputs();
        e_pc_write = 1; e_ifid_write = 1; e_ifid_flush = 0; e_idex_flush = 0;
        e_rv = 0; e_halted = 0; e_pc = '0;
        if (m_mode == M_RUN) begin
            if (ex_pc_sel) begin
                e_rv = 1; e_pc = ex_br_pc[PC_W-1:0]; e_ifid_flush = 1; e_idex_flush = 1;
            end else if (m_have_target) begin
                e_rv = 1; e_pc = m_target;
            end else if (!halt_req && model_load_use()) begin
                e_pc_write = 0; e_ifid_write = 0; e_idex_flush = 1;
            end
        end else if (m_mode == M_DRAIN) begin
            e_pc_write = 0; e_ifid_flush = 1;
        end else begin
            e_halted = 1; e_pc_write = 0; e_ifid_write = 0; e_idex_flush = 1;
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            model_reset();
        end else if (m_mode == M_RUN) begin
            if (ex_pc_sel) begin
                if (ex_br_pc[1:0] != 2'b00) m_sticky = 1;
                if (m_taken < 64'hFFFF_FFFF) m_taken++;
            end else if (!m_have_target && !halt_req && model_load_use()) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
            end
            m_have_target = 0;
            if (halt_req) begin
                m_mode = M_DRAIN;
                m_left = DRAIN_CYCLES;
            end
        end else if (m_mode == M_DRAIN) begin
            if (ex_pc_sel) begin
                m_have_target = 1;
                m_target = ex_br_pc[PC_W-1:0];
                if (ex_br_pc[1:0] != 2'b00) m_sticky = 1;
            end
            m_left--;
            if (m_left == 0) m_mode = M_HALTED;
        end else if (resume) begin
            m_mode = M_RUN;
        end
    endtask

    function automatic state_t mode_name(input int mode);
        if (mode == M_DRAIN) return DRAIN;
        if (mode == M_HALTED) return HALTED;
        return RUN;
    endfunction

    task automatic check_all();
        chk("pc_write", pc_write, e_pc_write);
        chk("ifid_write", ifid_write, e_ifid_write);
        chk("ifid_flush", ifid_flush, e_ifid_flush);
        chk("idex_flush", idex_flush, e_idex_flush);
        chk("redirect_valid", redirect_valid, e_rv);
        if (e_rv) chk("redirect_pc", redirect_pc, e_pc);
        chk("halted", halted, e_halted);
        chk("misalign_err", misalign_err, m_sticky);
        chk("state", dbg.state, mode_name(m_mode));
`ifdef REDIRECT_CTRL_PERF_EN
        chk("taken_count", taken_count, m_taken[31:0]);
        chk("stall_count", stall_count, m_stall[31:0]);
`else
        chk("taken_count", taken_count, 32'd0);
        chk("stall_count", stall_count, 32'd0);
`endif
    endtask

    // Inputs are held from the falling edge; outputs are compared 1 ns later.
    task automatic cycle();
        #1;
        model_outputs();
        check_all();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; ex_pc_sel = 0; ex_br_pc = 32'd0; idex_mem_read = 0;
        idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; halt_req = 0; resume = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        idle();

        // Reset state
        #1;
        chk("rst_halted", halted, 1'b0);
        chk("rst_misalign", misalign_err, 1'b0);
        chk("rst_rv", redirect_valid, 1'b0);
        chk("rst_taken", taken_count, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        cycle();

        // Taken branch to 0x40
        ex_pc_sel = 1; ex_br_pc = 32'h40;
        #1;
        chk("br40_pc", redirect_pc, 32'h40);
        chk("br40_flush", {ifid_flush, idex_flush}, 2'b11);
        cycle();
        idle();
        cycle();

        // Load-use on rs2, then load into x0
        idex_mem_read = 1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
        #1;
        chk("lu_stall", {pc_write, ifid_write, idex_flush}, 3'b001);
        cycle();
        idex_rd = 5'd0; ifid_rs2 = 5'd0;
        #1;
        chk("lu_x0", {pc_write, ifid_write, idex_flush}, 3'b110);
        cycle();
        idle();

        // Plain halt: three drain cycles, halt, resume without a target
        halt_req = 1;
        cycle();
        idle();
        for (int i = 0; i < DRAIN_CYCLES; i++) cycle();
        #1;
        chk("halt_done", halted, 1'b1);
        cycle();
        resume = 1;
        cycle();
        idle();
        #1;
        chk("resume_plain_rv", redirect_valid, 1'b0);
        cycle();

        // Branch captured in the second drain cycle replays after resume
        halt_req = 1;
        cycle();
        idle();
        cycle();
        ex_pc_sel = 1; ex_br_pc = 32'h88;
        cycle();
        idle();
        cycle();
        cycle();
        resume = 1;
        cycle();
        idle();
        #1;
        chk("resume_tgt_rv", redirect_valid, 1'b1);
        chk("resume_tgt_pc", redirect_pc, 32'h88);
        cycle();
        cycle();

        // Halt together with a misaligned redirect
        halt_req = 1; ex_pc_sel = 1; ex_br_pc = 32'h42;
        #1;
        chk("hr_br_rv", redirect_valid, 1'b1);
        chk("hr_br_pc", redirect_pc, 32'h42);
        cycle();
        idle();
        #1;
        chk("hr_br_drain", dbg.state, DRAIN);
        chk("misalign_set", misalign_err, 1'b1);
        for (int i = 0; i < DRAIN_CYCLES + 2; i++) cycle();
        resume = 1;
        cycle();
        idle();
        cycle();
        #1;
        chk("misalign_sticky", misalign_err, 1'b1);

        // Reset while halted with a latched target discards it
        halt_req = 1;
        cycle();
        idle();
        ex_pc_sel = 1; ex_br_pc = 32'h1F0;
        cycle();
        idle();
        for (int i = 0; i < DRAIN_CYCLES + 1; i++) cycle();
        reset = 1;
        cycle();
        idle();
        resume = 1;
        #1;
        chk("post_rst_rv", redirect_valid, 1'b0);
        chk("post_rst_misalign", misalign_err, 1'b0);
        cycle();
        idle();
        cycle();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            ex_pc_sel = ($urandom_range(0, 3) == 0);
            ex_br_pc = $urandom;
            idex_mem_read = $urandom_range(0, 1);
            idex_rd = 5'($urandom_range(0, 7));
            ifid_rs1 = 5'($urandom_range(0, 7));
            ifid_rs2 = 5'($urandom_range(0, 7));
            halt_req = ($urandom_range(0, 15) == 0);
            resume = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
